// File: rtl/gpio_debounce_bit.sv
// Single-bit debouncer: stability counter advanced on shared sample ticks,
// registered debounced level and one-cycle rise/fall pulses.
module gpio_debounce_bit #(
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic aclk,
  input  logic arstn,
  input  logic enable,
  input  logic tick,
  input  logic sync_i,
  input  logic rst_val,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntWidth = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_COUNT - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                deb_q, deb_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (!enable) begin
      cnt_d = '0;
      deb_d = sync_i;
    end else if (sync_i == deb_q) begin
      // Any return to the current level discards progress, tick or not.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CntLast) begin
        deb_d = sync_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      cnt_q  <= '0;
      deb_q  <= rst_val;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: pad synchronizer, shared sample-tick prescaler and
// per-bit debouncers producing the level for gpio_io_i plus edge pulses.
module gpio_in_debounce #(
  parameter int unsigned           GPIO_WIDTH     = 32,
  parameter int unsigned           SYNC_STAGES    = 2,
  parameter int unsigned           PRESCALE       = 100,
  parameter int unsigned           DEBOUNCE_COUNT = 4,
  parameter logic [GPIO_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic                  enable,
  input  logic [GPIO_WIDTH-1:0] gpio_raw_i,
  output logic [GPIO_WIDTH-1:0] gpio_deb_o,
  output logic [GPIO_WIDTH-1:0] gpio_rise_o,
  output logic [GPIO_WIDTH-1:0] gpio_fall_o,
  output logic                  tick_o
);

  localparam int unsigned PreWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreWidth-1:0] PreLast = PreWidth'(PRESCALE - 1);

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PreWidth-1:0]   pre_q, pre_d;
  logic                  tick;
  logic                  tick_q;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VALUE;
    end else begin
      sync_q[0] <= gpio_raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Prescaler parks at 0 in bypass so re-enabling starts a fresh tick period.
  always_comb begin
    tick  = enable && (pre_q == PreLast);
    pre_d = pre_q;
    if (!enable || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick;
    end
  end

  assign tick_o = tick_q;

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : gen_bit
    gpio_debounce_bit #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_bit (
      .aclk   (aclk),
      .arstn  (arstn),
      .enable (enable),
      .tick   (tick),
      .sync_i (sync_q[SYNC_STAGES-1][g]),
      .rst_val(RESET_VALUE[g]),
      .deb_o  (gpio_deb_o[g]),
      .rise_o (gpio_rise_o[g]),
      .fall_o (gpio_fall_o[g])
    );
  end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input conditioning stage that sits directly upstream of the `gpio_io_i` port of the AXI-lite GPIO core. It brings raw pad inputs into the `aclk` domain through a synchronizer and debounces each bit with a shared sample-tick prescaler and a per-bit stability counter. It emits the debounced vector plus one-cycle rise and fall pulses per bit. The debounced vector connects straight to `gpio_io_i`; the edge pulses are available for interrupt or event logic.

## Interface
- `GPIO_WIDTH`, 32, number of input bits.
- `SYNC_STAGES`, 2, synchronizer depth; must be ≥ 2.
- `PRESCALE`, 100, `aclk` cycles per sample tick; must be ≥ 1.
- `DEBOUNCE_COUNT`, 4, consecutive ticks a new level must persist; must be ≥ 1.
- `RESET_VALUE`, 0, GPIO_WIDTH-bit reset value of the synchronizer and debounced registers.
- `aclk`  in  1  clock; single clock domain.
- `arstn`  in  1  reset; asynchronous assert, active-low.
- `enable`  in  1  1 = debounce active; 0 = bypass (debounced output follows the synchronizer).
- `gpio_raw_i`  in  GPIO_WIDTH  asynchronous pad inputs.
- `gpio_deb_o`  out  GPIO_WIDTH  debounced level; drives `gpio_io_i`.
- `gpio_rise_o`  out  GPIO_WIDTH  one-cycle pulse per bit on a debounced 0→1 transition.
- `gpio_fall_o`  out  GPIO_WIDTH  one-cycle pulse per bit on a debounced 1→0 transition.
- `tick_o`  out  1  sample tick strobe (debug/observability).

## Operation
- **Reset** (`arstn` = 0):
  - Synchronizer flops and `gpio_deb_o` take `RESET_VALUE`.
  - Counters, prescaler, `gpio_rise_o`, `gpio_fall_o` and `tick_o` are all 0.
- **Synchronizer:** `SYNC_STAGES` flops per bit. Only the last stage is used downstream.
- **Prescaler:** counts 0..PRESCALE-1, then wraps to 0. `tick` is high for exactly one cycle when the count equals PRESCALE-1. With PRESCALE = 1, `tick` is high every cycle. `tick_o` is the registered tick.
- **Per-bit counter** (width `$clog2(DEBOUNCE_COUNT+1)`), evaluated each cycle:
  - sync == deb: counter ← 0.
  - sync != deb and tick: if counter == DEBOUNCE_COUNT-1, then deb ← sync and counter ← 0; otherwise counter increments.
  - sync != deb and no tick: counter holds.
  - A glitch back to the current deb level clears the counter on any cycle, tick or not.
- **Edge pulses:** registered on the same edge that updates `gpio_deb_o`.
  - rise = new & ~old; fall = ~new & old.
  - Each pulse is high for exactly one cycle and is coincident with the new `gpio_deb_o` value.
- **Bypass** (`enable` = 0):
  - Prescaler is held at 0, `tick` = 0, counters are 0.
  - deb ← sync every cycle, and edge pulses are still generated.
  - When `enable` goes 0→1, all counters start from 0.
- **Bit independence:** bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.

## Timing
- **Synchronizer latency:** `SYNC_STAGES` cycles from a raw change to the sync output.
- **Debounce latency, PRESCALE = 1:** `gpio_deb_o` changes exactly SYNC_STAGES + DEBOUNCE_COUNT cycles after a clean raw change.
- **Debounce latency, PRESCALE > 1:** between SYNC_STAGES + (DEBOUNCE_COUNT-1)·PRESCALE + 1 and SYNC_STAGES + DEBOUNCE_COUNT·PRESCALE cycles, depending on prescaler phase.
- **Bypass latency:** SYNC_STAGES + 1 cycles.
- **Rejection:** any pulse shorter than the debounce window is rejected, and produces no edge pulse.
- **Reset mid-count:** asserting `arstn` during a count discards all progress. After release, a full window is required again.
- **No handshake:** outputs are level/pulse only, with no backpressure.

## Structure
- **No shared package.** The counter width is a localparam computed with `$clog2` inside the module.
- **Sub-module `gpio_debounce_bit`:** one instance per bit via a generate loop. Inputs: `aclk`, `arstn`, `enable`, `tick`, `sync_i`, reset bit. Outputs: `deb_o`, `rise_o`, `fall_o`.
- **Top level** holds the synchronizer, prescaler and generate loop.

## Test plan
All scenarios use GPIO_WIDTH = 4, SYNC_STAGES = 2, DEBOUNCE_COUNT = 4, RESET_VALUE = 0, and PRESCALE = 1 unless noted.
- **Reset:** `arstn` low with `gpio_raw_i` = 4'hF → `gpio_deb_o` = 0, pulses 0, `tick_o` 0 while in reset.
- **Clean rise:** `gpio_raw_i[0]` 0→1 held → `gpio_deb_o[0]` = 1 exactly 6 cycles later. `gpio_rise_o[0]` is high for that single cycle; other bits are unchanged.
- **Glitch rejection:** `gpio_raw_i[1]` high for 3 cycles, then low → `gpio_deb_o[1]` stays 0, and rise/fall pulses stay 0 throughout.
- **Prescaled debounce:** PRESCALE = 10, `gpio_raw_i[2]` 0→1 held → `tick_o` every 10 cycles, and `gpio_deb_o[2]` rises within 33..42 cycles. Releasing to 0 gives `gpio_fall_o[2]` as a one-cycle pulse after the same window.
- **Bypass:** `enable` = 0, `gpio_raw_i[3]` toggles every 5 cycles → `gpio_deb_o[3]` follows 3 cycles later, with alternating one-cycle rise/fall pulses.
- **Reset mid-count:** raw[0] = 1 for 4 cycles, then `arstn` pulsed low → all outputs 0. After release with raw[0] still 1, `gpio_deb_o[0]` rises exactly 6 cycles later.
